r88_busctl: RTL and testbench

Parametrised memory bus controller for the Rocket88 core, the successor to `r88_mc`. It holds the address register, with full, low and high loads and optional post-increment. It sequences one read or write per request using configurable wait states and a `memReady` stretch input, and returns a done pulse with captured read data to the decoder. The data bus is split into in, out and output-enable, so the tristate lives at the core top level.

---
 rtl/r88_pkg.sv | 17 +
 rtl/r88_bus_timer.sv | 23 ++
 rtl/r88_busctl.sv | 174 +++++++++++++++++
 tb/tb_r88_busctl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r88_pkg.sv
// Shared types and default widths for the Rocket88 memory bus controller.
package r88_pkg;

    localparam int R88_ADDR_W = 16;
    localparam int R88_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } bus_state_e;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } bus_dir_e;

endpackage

// File: rtl/r88_bus_timer.sv
// Loadable down-counter; stops at zero. Terminal-count compare is left to the user.
module r88_bus_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/r88_busctl.sv
// Rocket88 memory bus controller: address register, one access per request, done pulse.
// Optional access timeout enabled by defining R88_BUS_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for a request; address loads accepted; done cycle lives here
//   ACCESS | strobe held; wait states, then memReady stretch (or timeout abort)
module r88_busctl
    import r88_pkg::*;
#(
    parameter int ADDR_W      = R88_ADDR_W,
    parameter int DATA_W      = R88_DATA_W,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic              sysClock,
    input  logic              resetReqN,
    input  logic              reqRead,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic              addrWrFull,
    input  logic              addrWrLow,
    input  logic              addrWrHigh,
    input  logic              addrInc,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              busy,
    output logic              done,
    output logic              busErr,
    output logic [ADDR_W-1:0] extA,
    input  logic [DATA_W-1:0] extDIn,
    output logic [DATA_W-1:0] extDOut,
    output logic              extDOe,
    output logic              readMem,
    output logic              writeMem,
    input  logic              memReady
);

    if (ADDR_W <= 8 || WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 0) begin : g_param_check
        $error("r88_busctl: illegal parameter value");
    end

    bus_state_e        state;
    bus_state_e        state_next;
    bus_dir_e          dir_q;
    logic              inc_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              done_q;
    logic              err_q;
    logic              rd_stb_q;
    logic              wr_stb_q;
    logic              oe_q;

    logic              in_access;
    logic              accept;
    logic              wait_zero;
    logic              finish;
    logic              abort;
    logic [3:0]        wait_count;

    assign in_access = (state == ACCESS);
    assign accept    = (state == IDLE) && (reqRead || reqWrite);
    assign wait_zero = (wait_count == 4'd0);
    assign finish    = in_access && wait_zero && memReady;

    r88_bus_timer #(.W(4)) u_wait (
        .clk      (sysClock),
        .rst_n    (resetReqN),
        .load     (accept),
        .load_val (4'(WAIT_STATES)),
        .dec      (in_access),
        .count    (wait_count)
    );

`ifdef R88_BUS_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic             stretch;
    logic [TMO_W-1:0] tmo_count;

    assign stretch = in_access && wait_zero && !memReady;

    r88_bus_timer #(.W(TMO_W)) u_tmo (
        .clk      (sysClock),
        .rst_n    (resetReqN),
        .load     (accept),
        .load_val (TMO_W'(TIMEOUT)),
        .dec      (stretch),
        .count    (tmo_count)
    );

    // This stretch cycle is the TIMEOUT-th one when the counter sits at its last step.
    assign abort = stretch && (tmo_count <= TMO_W'(1));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge sysClock or negedge resetReqN) begin
        if (!resetReqN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  if (finish || abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysClock or negedge resetReqN) begin
        if (!resetReqN) begin
            dir_q     <= DIR_READ;
            inc_q     <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_stb_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            done_q <= finish || abort;
            err_q  <= abort;

            // Read wins when both requests arrive together.
            if (accept) begin
                dir_q    <= reqRead ? DIR_READ : DIR_WRITE;
                inc_q    <= addrInc;
                wdata_q  <= wrData;
                rd_stb_q <= reqRead;
                wr_stb_q <= !reqRead;
                oe_q     <= !reqRead;
            end else if (finish || abort) begin
                rd_stb_q <= 1'b0;
                wr_stb_q <= 1'b0;
                oe_q     <= 1'b0;
            end

            if (finish && (dir_q == DIR_READ)) begin
                rd_data_q <= extDIn;
            end

            // Loads only while idle and not in a request cycle, so extA holds through the access.
            if (finish && inc_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end else if ((state == IDLE) && !accept) begin
                if (addrWrFull) begin
                    addr_q <= addrIn;
                end else begin
                    if (addrWrLow)  addr_q[7:0]        <= addrIn[7:0];
                    if (addrWrHigh) addr_q[ADDR_W-1:8] <= addrIn[ADDR_W-9:0];
                end
            end
        end
    end

    assign busy     = in_access;
    assign done     = done_q;
    assign busErr   = err_q;
    assign rdData   = rd_data_q;
    assign extA     = addr_q;
    assign extDOut  = wdata_q;
    assign extDOe   = oe_q;
    assign readMem  = rd_stb_q;
    assign writeMem = wr_stb_q;

endmodule

// File: tb/tb_r88_busctl.sv
// Bench for r88_busctl: two instances (WAIT_STATES 0 and 2) share stimulus; directed table,
// hand sequences and random traffic checked against a transaction-level reference model.
module tb_r88_busctl;

    localparam int TMO = 4;

    typedef struct packed {
        logic [7:0]  rd_data;
        logic        busy;
        logic        done;
        logic        bus_err;
        logic [15:0] ext_a;
        logic [7:0]  ext_d_out;
        logic        ext_d_oe;
        logic        read_mem;
        logic        write_mem;
    } out_t;

    typedef struct {
        bit          acc;
        bit          is_rd;
        bit          inc;
        logic [7:0]  wd;
        int          cyc;
        int          stall;
        logic [15:0] addr;
        logic [7:0]  rd;
        bit          done;
        bit          err;
    } mdl_t;

    typedef struct {
        bit          rr, rw, full, low, high, inc, rdy;
        logic [15:0] ain;
        logic [7:0]  wd, din;
        logic [15:0] ea;
        bit          busy, rd, wr, done;
        logic [7:0]  rdd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [15:0] addr_in = '0;
    logic        addr_wr_full = 1'b0, addr_wr_low = 1'b0, addr_wr_high = 1'b0, addr_inc = 1'b0;
    logic [7:0]  wr_data = '0, ext_d_in = '0;
    logic        mem_ready = 1'b1;
    out_t        o0, o2;

    int checks = 0;
    int errors = 0;
    mdl_t m [2];
    vec_t vt [14];
    int dk, cnt, bad;
    bit err_seen;
    logic [7:0] exp_rd;

    always #5 clk = ~clk;

    r88_busctl #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(0), .TIMEOUT(TMO)) u_dut0 (
        .sysClock(clk), .resetReqN(rst_n), .reqRead(req_read), .reqWrite(req_write),
        .addrIn(addr_in), .addrWrFull(addr_wr_full), .addrWrLow(addr_wr_low),
        .addrWrHigh(addr_wr_high), .addrInc(addr_inc), .wrData(wr_data),
        .rdData(o0.rd_data), .busy(o0.busy), .done(o0.done), .busErr(o0.bus_err),
        .extA(o0.ext_a), .extDIn(ext_d_in), .extDOut(o0.ext_d_out), .extDOe(o0.ext_d_oe),
        .readMem(o0.read_mem), .writeMem(o0.write_mem), .memReady(mem_ready)
    );

    r88_busctl #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(2), .TIMEOUT(TMO)) u_dut2 (
        .sysClock(clk), .resetReqN(rst_n), .reqRead(req_read), .reqWrite(req_write),
        .addrIn(addr_in), .addrWrFull(addr_wr_full), .addrWrLow(addr_wr_low),
        .addrWrHigh(addr_wr_high), .addrInc(addr_inc), .wrData(wr_data),
        .rdData(o2.rd_data), .busy(o2.busy), .done(o2.done), .busErr(o2.bus_err),
        .extA(o2.ext_a), .extDIn(ext_d_in), .extDOut(o2.ext_d_out), .extDOe(o2.ext_d_oe),
        .readMem(o2.read_mem), .writeMem(o2.write_mem), .memReady(mem_ready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: an access lasts ws cycles of waiting, then completes on the
    // first ready cycle; stall cycles beyond the wait count toward the timeout.
    task automatic step(input int ws, inout mdl_t s);
        s.done = 1'b0;
        s.err  = 1'b0;
        if (!s.acc) begin
            if (req_read || req_write) begin
                s.acc = 1'b1; s.is_rd = req_read; s.inc = addr_inc; s.wd = wr_data;
                s.cyc = 0; s.stall = 0;
            end else if (addr_wr_full) begin
                s.addr = addr_in;
            end else begin
                if (addr_wr_low)  s.addr[7:0]  = addr_in[7:0];
                if (addr_wr_high) s.addr[15:8] = addr_in[7:0];
            end
        end else begin
            s.cyc++;
            if (s.cyc > ws) begin
                if (mem_ready) begin
                    if (s.is_rd) s.rd = ext_d_in;
                    if (s.inc) s.addr = s.addr + 16'd1;
                    s.done = 1'b1;
                    s.acc  = 1'b0;
                end else begin
                    s.stall++;
`ifdef R88_BUS_TIMEOUT_EN
                    if (s.stall >= TMO) begin
                        s.done = 1'b1; s.err = 1'b1; s.acc = 1'b0;
                    end
`endif
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) m[i] = '{default: '0};
        end else begin
            step(0, m[0]);
            step(2, m[1]);
        end
    end

    task automatic cmp(input string tag, input out_t o, input mdl_t s);
        check({tag, "busy"},  o.busy,      s.acc);
        check({tag, "rdstb"}, o.read_mem,  s.acc && s.is_rd);
        check({tag, "wrstb"}, o.write_mem, s.acc && !s.is_rd);
        check({tag, "oe"},    o.ext_d_oe,  s.acc && !s.is_rd);
        check({tag, "done"},  o.done,      s.done);
        check({tag, "err"},   o.bus_err,   s.err);
        check({tag, "addr"},  o.ext_a,     s.addr);
        check({tag, "rdata"}, o.rd_data,   s.rd);
        if (s.acc && !s.is_rd) check({tag, "dout"}, o.ext_d_out, s.wd);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("m0_", o0, m[0]);
            cmp("m2_", o2, m[1]);
        end
    end

    task automatic idle_inputs();
        req_read = 1'b0; req_write = 1'b0; addr_wr_full = 1'b0; addr_wr_low = 1'b0;
        addr_wr_high = 1'b0; addr_inc = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        idle_inputs();
        while ((o0.busy || o2.busy) && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_idle_bound", n < 60, 1);
    endtask

    task automatic apply(input vec_t v);
        req_read = v.rr; req_write = v.rw; addr_wr_full = v.full; addr_wr_low = v.low;
        addr_wr_high = v.high; addr_inc = v.inc; mem_ready = v.rdy; addr_in = v.ain;
        wr_data = v.wd; ext_d_in = v.din;
    endtask

    function automatic vec_t mk(input bit rr, rw, full, low, high, rdy,
                                input logic [15:0] ain, input logic [7:0] wd, din,
                                input logic [15:0] ea, input bit busy, rd, wr, done,
                                input logic [7:0] rdd);
        vec_t v;
        v.rr = rr; v.rw = rw; v.full = full; v.low = low; v.high = high; v.inc = 1'b0;
        v.rdy = rdy; v.ain = ain; v.wd = wd; v.din = din; v.ea = ea; v.busy = busy;
        v.rd = rd; v.wr = wr; v.done = done; v.rdd = rdd;
        return v;
    endfunction

    initial begin
        //            rr rw fu lo hi rdy ain       wd     din    | ea        bsy rd wr dn rdd
        vt[0]  = mk(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00);
        vt[1]  = mk(0, 0, 1, 0, 0, 1, 16'h1234, 8'h00, 8'h00, 16'h1234, 0, 0, 0, 0, 8'h00);
        vt[2]  = mk(1, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 8'hA5, 16'h1234, 1, 1, 0, 0, 8'h00);
        vt[3]  = mk(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 8'hA5, 16'h1234, 0, 0, 0, 1, 8'hA5);
        vt[4]  = mk(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 8'h00, 16'h1234, 0, 0, 0, 0, 8'hA5);
        vt[5]  = mk(0, 0, 0, 1, 0, 1, 16'hAB78, 8'h00, 8'h00, 16'h1278, 0, 0, 0, 0, 8'hA5);
        vt[6]  = mk(0, 0, 0, 0, 1, 1, 16'h0056, 8'h00, 8'h00, 16'h5678, 0, 0, 0, 0, 8'hA5);
        vt[7]  = mk(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h11, 16'h5678, 1, 1, 0, 0, 8'hA5);
        vt[8]  = mk(0, 0, 1, 0, 0, 0, 16'hFFFF, 8'h00, 8'h11, 16'h5678, 1, 1, 0, 0, 8'hA5);
        vt[9]  = mk(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 8'h22, 16'h5678, 0, 0, 0, 1, 8'h22);
        vt[10] = mk(0, 1, 1, 0, 0, 1, 16'h0F0F, 8'h99, 8'h00, 16'h5678, 1, 0, 1, 0, 8'h22);
        vt[11] = mk(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 8'h00, 16'h5678, 0, 0, 0, 1, 8'h22);
        vt[12] = mk(0, 0, 0, 1, 1, 1, 16'h1ABC, 8'h00, 8'h00, 16'hBCBC, 0, 0, 0, 0, 8'h22);
        vt[13] = mk(0, 0, 1, 1, 0, 1, 16'h4321, 8'h00, 8'h00, 16'h4321, 0, 0, 0, 0, 8'h22);

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check("rst_addr", o0.ext_a, 0);
        check("rst_rdata", o0.rd_data, 0);
        check("rst_busy", o0.busy, 0);
        check("rst_strobes", {o0.read_mem, o0.write_mem, o0.ext_d_oe}, 0);
        check("rst_done_err", {o0.done, o0.bus_err}, 0);
        #1 rst_n = 1'b1;

        foreach (vt[i]) begin
            apply(vt[i]);
            @(negedge clk);
            check($sformatf("vec%0d_addr", i), o0.ext_a, vt[i].ea);
            check($sformatf("vec%0d_busy", i), o0.busy, vt[i].busy);
            check($sformatf("vec%0d_rd", i), o0.read_mem, vt[i].rd);
            check($sformatf("vec%0d_wr", i), {o0.write_mem, o0.ext_d_oe}, {vt[i].wr, vt[i].wr});
            check($sformatf("vec%0d_done", i), o0.done, vt[i].done);
            check($sformatf("vec%0d_rdata", i), o0.rd_data, vt[i].rdd);
            if (vt[i].wr) check($sformatf("vec%0d_dout", i), o0.ext_d_out, vt[i].wd);
            #1;
        end

        // Write with two wait states at 0xFFFF, post-increment wraps to 0
        wait_idle();
        addr_wr_full = 1'b1; addr_in = 16'hFFFF;
        @(negedge clk); #1;
        idle_inputs();
        req_write = 1'b1; wr_data = 8'h3C; addr_inc = 1'b1;
        cnt = 0; bad = 0; dk = 0;
        for (int k = 1; k <= 10 && dk == 0; k++) begin
            @(negedge clk);
            if (o2.write_mem) begin
                cnt++;
                if (!o2.ext_d_oe || o2.ext_d_out !== 8'h3C || o2.ext_a !== 16'hFFFF) bad++;
            end
            if (o2.done) dk = k;
            #1;
            req_write = 1'b0; addr_inc = 1'b0;
        end
        check("ws2_strobe_cycles", cnt, 3);
        check("ws2_done_latency", dk, 4);
        check("ws2_strobe_content", bad, 0);
        check("ws2_addr_wrap", o2.ext_a, 16'h0000);
        check("ws0_addr_wrap", o0.ext_a, 16'h0000);

        // memReady low for 3 cycles, then a back-to-back request in the done cycle
        wait_idle();
        req_read = 1'b1; mem_ready = 1'b0; ext_d_in = 8'h5A;
        dk = 0;
        for (int k = 1; k <= 12 && dk == 0; k++) begin
            @(negedge clk);
            if (o0.done) dk = k;
            #1;
            req_read = 1'b0;
            mem_ready = (k >= 4);
        end
        check("stretch_done_latency", dk, 5);
        check("stretch_rdata", o0.rd_data, 8'h5A);
        req_read = 1'b1; ext_d_in = 8'h6B;
        @(negedge clk);
        check("b2b_strobe", o0.read_mem, 1);
        check("b2b_busy", o0.busy, 1);
        #1;
        idle_inputs();

        // memReady held low: timeout abort (or indefinite wait without the feature)
        wait_idle();
        exp_rd = m[0].rd;
        req_read = 1'b1; mem_ready = 1'b0; ext_d_in = 8'hEE;
        cnt = 0; dk = 0; err_seen = 1'b0;
        for (int k = 1; k <= 20 && dk == 0; k++) begin
            @(negedge clk);
            if (o0.read_mem) cnt++;
            if (o0.done) begin
                dk = k;
                err_seen = o0.bus_err;
            end
            #1;
            req_read = 1'b0;
        end
`ifdef R88_BUS_TIMEOUT_EN
        check("tmo_done_latency", dk, 5);
        check("tmo_strobe_cycles", cnt, 4);
        check("tmo_bus_err", err_seen, 1);
        check("tmo_rdata_kept", o0.rd_data, exp_rd);
`else
        check("notmo_no_done", dk, 0);
        check("notmo_still_strobing", o0.read_mem, 1);
        check("notmo_bus_err", o0.bus_err, 0);
`endif

        // Reset asserted mid-access clears outputs immediately; no done follows
        wait_idle();
        addr_wr_full = 1'b1; addr_in = 16'h2468;
        @(negedge clk); #1;
        idle_inputs();
        req_write = 1'b1; mem_ready = 1'b0; wr_data = 8'h77;
        @(negedge clk); #1;
        req_write = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_strobes0", {o0.read_mem, o0.write_mem, o0.ext_d_oe, o0.busy}, 0);
        check("rstmid_strobes2", {o2.read_mem, o2.write_mem, o2.ext_d_oe, o2.busy}, 0);
        check("rstmid_addr", o0.ext_a, 0);
        check("rstmid_rdata", o0.rd_data, 0);
        check("rstmid_done_err", {o0.done, o0.bus_err, o2.done, o2.bus_err}, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o0.done || o2.done) cnt++;
            #1;
        end
        check("rstmid_no_done", cnt, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_read     = ($urandom_range(0, 3) == 0);
            req_write    = ($urandom_range(0, 3) == 0);
            addr_wr_full = ($urandom_range(0, 7) == 0);
            addr_wr_low  = ($urandom_range(0, 5) == 0);
            addr_wr_high = ($urandom_range(0, 5) == 0);
            addr_inc     = ($urandom_range(0, 1) == 1);
            mem_ready    = ($urandom_range(0, 3) != 0);
            addr_in      = 16'($urandom);
            wr_data      = 8'($urandom);
            ext_d_in     = 8'($urandom);
            @(negedge clk); #1;
        end
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
